// File: rtl/div_share_arb.sv
// div_share_arb
//   Round-robin arbiter and sequencer that shares one iterative divider among
//   NREQ requesters. One job at a time is accepted over a per-requester
//   valid/ready handshake. Each job either completes locally (divide-by-zero)
//   or runs on the divider with a watchdog. Its result is then returned on a
//   single valid/ready response port.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[NREQ]   job request per requester
//   req_ready[NREQ]   one-hot accept; the handshake completes in the grant cycle
//   req_dividend      packed dividends, requester i at [i*BITS +: BITS]
//   req_divisor       packed divisors, same packing
//   rsp_valid/ready   response handshake
//   rsp_id            requester index of the response
//   rsp_quotient      quotient (all ones on divide-by-zero, 0 on timeout)
//   rsp_remainder     remainder (dividend on divide-by-zero, 0 on timeout)
//   rsp_err           00 ok, 01 divide-by-zero, 10 timeout
//   div_enable        divider enable, high for the duration of a division
//   div_a, div_b      divider operands, stable while div_enable is high
//   div_c, div_d      divider quotient / remainder
//   div_done          divider completion level; only its rising edge counts
module div_share_arb #(
  parameter int BITS    = 48,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*BITS-1:0] req_dividend,
  input  logic [NREQ*BITS-1:0] req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [BITS-1:0]    rsp_quotient,
  output logic [BITS-1:0]    rsp_remainder,
  output logic [1:0]         rsp_err,
  output logic               div_enable,
  output logic [BITS-1:0]    div_a,
  output logic [BITS-1:0]    div_b,
  input  logic [BITS-1:0]    div_c,
  input  logic [BITS-1:0]    div_d,
  input  logic               div_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]      state;
  logic [IDW-1:0]  rr_ptr;
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic            done_q;
  logic [TW-1:0]   timer;

  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  rr_next;
  logic [BITS-1:0] sel_a;
  logic [BITS-1:0] sel_b;
  logic            accept;
  logic            done_rise;
  logic            timed_out;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld && req_valid[(k + int'(rr_ptr)) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((k + int'(rr_ptr)) % NREQ);
      end
    end
  end

  assign sel_a   = req_dividend[int'(grant_idx)*BITS +: BITS];
  assign sel_b   = req_divisor[int'(grant_idx)*BITS +: BITS];
  assign rr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);

  // Gated by rst_n so no accept is ever advertised while held in reset.
  assign accept    = rst_n && (state == S_IDLE) && grant_vld;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state == S_RESP);

  // Only a fresh rising edge of the level-type done is trusted; a done left
  // high from before launch is masked by done_q sampled during LAUNCH.
  assign done_rise = div_done && !done_q;
  assign timed_out = (timer == TW'(TIMEOUT-1));

  // Accept stage: operand capture for the launch that follows.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= sel_a;
      op_b <= sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= 2'b00;
      div_enable    <= 1'b0;
      div_a         <= '0;
      div_b         <= BITS'(1);
      done_q        <= 1'b0;
      timer         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rr_ptr <= rr_next;
            rsp_id <= grant_idx;
            if (sel_b == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_a;
              rsp_err       <= 2'b01;
              state         <= S_RESP;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        // Launch stage: present operands and start the divider.
        S_LAUNCH: begin
          div_a      <= op_a;
          div_b      <= op_b;
          div_enable <= 1'b1;
          timer      <= '0;
          done_q     <= div_done;
          state      <= S_WAIT;
        end
        // Wait stage: completion edge or watchdog expiry.
        S_WAIT: begin
          done_q <= div_done;
          timer  <= timer + TW'(1);
          if (done_rise) begin
            rsp_quotient  <= div_c;
            rsp_remainder <= div_d;
            rsp_err       <= 2'b00;
            div_enable    <= 1'b0;
            state         <= S_RESP;
          end else if (timed_out) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= 2'b10;
            div_enable    <= 1'b0;
            state         <= S_RESP;
          end
        end
        // Response stage: hold results until consumed.
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
